// File: rtl/systolic_writeback.sv
// Collects per-row result beats from a systolic array into N2-word row segments and
// drains them in row order with matrix addressing. Define WB_OVF_DETECT_EN for the sticky overflow flag.
module systolic_writeback_row #(
  parameter int D_W_ACC = 16,
  parameter int N2      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [D_W_ACC-1:0]       d,
  input  logic                     vld,
  input  logic                     pop,
  output logic                     nonempty,
  output logic [N2*D_W_ACC-1:0]    head
`ifdef WB_OVF_DETECT_EN
  , output logic                   drop
`endif
);
  localparam int KW = (N2 > 1) ? $clog2(N2) : 1;

  logic [KW-1:0]                    k;
  logic [N2-1:0][D_W_ACC-1:0]       slot, seg;
  logic [1:0][N2-1:0][D_W_ACC-1:0]  mem;
  logic                             rd_ptr, wr_ptr;
  logic [1:0]                       cnt;
  logic                             push, full, push_ok, pop_ok;

  assign push    = vld && (k == KW'(N2-1));
  assign full    = (cnt == 2'd2);
  assign pop_ok  = pop && (cnt != 2'd0);
  // a full FIFO still accepts a push when it is popped in the same cycle
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    seg    = slot;
    seg[k] = d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k      <= '0;
      slot   <= '0;
      mem    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (vld) begin
        slot[k] <= d;
        k       <= (k == KW'(N2-1)) ? '0 : k + 1'b1;
      end
      if (push_ok) begin
        mem[wr_ptr] <= seg;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign nonempty = (cnt != 2'd0);
  assign head     = mem[rd_ptr];
`ifdef WB_OVF_DETECT_EN
  assign drop     = push && full && !pop_ok;
`endif
endmodule

module systolic_writeback #(
  parameter int D_W_ACC = 16,
  parameter int N1      = 4,
  parameter int N2      = 4,
  parameter int M       = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N1-1:0][D_W_ACC-1:0]       D,
  input  logic [N1-1:0]                    valid_D,
  output logic                             wr_valid,
  input  logic                             wr_ready,
  output logic [$clog2(M*M/N2)-1:0]        wr_addr,
  output logic [N2*D_W_ACC-1:0]            wr_data,
  output logic                             done,
  output logic                             ovf
);
  localparam int AW  = $clog2(M*M/N2);
  localparam int SW  = N2*D_W_ACC;
  localparam int RW  = (N1 > 1) ? $clog2(N1) : 1;
  localparam int SCW = ((M/N2) > 1) ? $clog2(M/N2) : 1;
  localparam int SRW = ((M/N1) > 1) ? $clog2(M/N1) : 1;

  logic [RW-1:0]           r;
  logic [SCW-1:0]          sc;
  logic [SRW-1:0]          sr;
  logic [N1-1:0]           nonempty, pop;
  logic [N1-1:0][SW-1:0]   head;
  logic                    accept, r_last, sc_last, sr_last;

  assign wr_valid = nonempty[r];
  assign wr_data  = head[r];
  assign accept   = wr_valid && wr_ready;
  assign r_last   = (r  == RW'(N1-1));
  assign sc_last  = (sc == SCW'(M/N2-1));
  assign sr_last  = (sr == SRW'(M/N1-1));
  assign wr_addr  = AW'((32'(sr) * 32'(N1) + 32'(r)) * 32'(M/N2) + 32'(sc));

`ifdef WB_OVF_DETECT_EN
  logic [N1-1:0] drop;
`endif

  for (genvar i = 0; i < N1; i++) begin : g_row
    assign pop[i] = accept && (r == RW'(i));
    systolic_writeback_row #(.D_W_ACC(D_W_ACC), .N2(N2)) u_row (
      .clk      (clk),
      .rst      (rst),
      .d        (D[i]),
      .vld      (valid_D[i]),
      .pop      (pop[i]),
      .nonempty (nonempty[i]),
      .head     (head[i])
`ifdef WB_OVF_DETECT_EN
      , .drop   (drop[i])
`endif
    );
  end

  // row pointer is the fastest-moving address digit, then column slice, then row slice
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r    <= '0;
      sc   <= '0;
      sr   <= '0;
      done <= 1'b0;
    end else begin
      done <= accept && r_last && sc_last && sr_last;
      if (accept) begin
        r <= r_last ? '0 : r + 1'b1;
        if (r_last) begin
          sc <= sc_last ? '0 : sc + 1'b1;
          if (sc_last) sr <= sr_last ? '0 : sr + 1'b1;
        end
      end
    end
  end

`ifdef WB_OVF_DETECT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf <= 1'b0;
    else if (|drop) ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: doc/systolic_writeback.md
SYSTOLIC_WRITEBACK -- requirements
Module: systolic_writeback

Interface
REQ-001 SHALL have parameter D_W_ACC, default 16: result word width.
REQ-002 SHALL have parameter N1, default 4: systolic array rows.
REQ-003 SHALL have parameter N2, default 4: systolic array columns, and words per row segment.
REQ-004 SHALL have parameter M, default 8: matrix dimension; M divisible by N1 and by N2.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port D, input, N1 x D_W_ACC: per-row result beats from the array.
REQ-008 SHALL have port valid_D, input, N1: per-row beat qualifier.
REQ-009 SHALL have port wr_valid, output, 1: a row segment is presented.
REQ-010 SHALL have port wr_ready, input, 1: the sink accepts the segment.
REQ-011 SHALL have port wr_addr, output, $clog2(M*M/N2): segment address.
REQ-012 SHALL have port wr_data, output, N2*D_W_ACC: segment; beat k in bits [k*D_W_ACC +: D_W_ACC].
REQ-013 SHALL have port done, output, 1: one-cycle pulse when the matrix is complete.
REQ-014 SHALL have port ovf, output, 1: sticky overflow flag.

Function
REQ-015 SHALL give each row i a beat counter k (0..N2-1) that, on valid_D[i]=1, stores D[i] into assembly slot k and increments k.
REQ-016 SHALL hold k and the slots when valid_D[i]=0 mid-segment, with no timeout; capture resumes on the next valid beat.
REQ-017 SHALL, on the beat with k=N2-1, push the assembled segment into row FIFO i (depth 2) at the same edge and wrap k to 0.
REQ-018 SHALL drain FIFOs strictly in row order: row pointer r from 0 to N1-1, then wraps to 0; it SHALL never skip a row.
REQ-019 SHALL drive wr_valid=1 exactly while FIFO r is non-empty, with wr_data equal to the head of FIFO r.
REQ-020 SHALL pop FIFO r and advance r on any cycle where wr_valid=1 and wr_ready=1.
REQ-021 SHALL hold wr_data and wr_addr stable while wr_valid=1 and wr_ready=0.
REQ-022 SHALL meet this latency: with FIFO r empty and r current, wr_valid rises in the cycle after the edge that captured beat N2-1.
REQ-023 SHALL form wr_addr = ((sr*N1 + r)*(M/N2)) + sc, where sr is the row-slice counter (0..M/N1-1) and sc is the column-slice counter (0..M/N2-1).
REQ-024 SHALL, when r wraps, increment sc; when sc wraps, increment sr.
REQ-025 SHALL, on the accepted segment with sr=M/N1-1, sc=M/N2-1 and r=N1-1, pulse done for one cycle, wrap all counters to 0 and continue with the next matrix.
REQ-026 SHALL let a push and a pop on the same FIFO in one cycle both take effect; occupancy is unchanged.
REQ-027 SHALL drop a push to a full FIFO without popping, keeping the existing contents intact.

Reset
REQ-028 SHALL, while rst=0, asynchronously clear all beat counters, FIFOs, r, sc and sr.
REQ-029 SHALL hold these output values during reset: wr_valid=0, wr_addr=0, wr_data=0, done=0, ovf=0.
REQ-030 SHALL, on reset asserted mid-matrix, discard partial segments and restart at address 0 after release.

Configuration
REQ-031 SHALL, with WB_OVF_DETECT_EN defined, set ovf=1 on any dropped push (REQ-027) and hold it until reset.
REQ-032 SHALL, without WB_OVF_DETECT_EN, tie ovf to 0 and compile in no overflow logic; drop behaviour is unchanged.

Verification
REQ-033 SHALL cover single segment (N1=N2=4, M=8): row 0 beats 0x11,0x22,0x33,0x44 on valid_D[0], wr_ready=1 -> one cycle later wr_valid=1, wr_addr=0, wr_data=0x0044_0033_0022_0011.
REQ-034 SHALL cover a full tile: rows 0..3 skewed by 1 cycle each -> four segments at wr_addr 0,2,4,6, in order.
REQ-035 SHALL cover backpressure: wr_ready=0 for 5 cycles with a segment pending -> wr_valid, wr_addr and wr_data held constant; resume on wr_ready=1.
REQ-036 SHALL cover a full matrix: 4 tiles streamed -> 16 segments, last at wr_addr 15, done pulses exactly once, and the next segment is at wr_addr 0.
REQ-037 SHALL cover overflow: wr_ready=0 while row 1 completes 3 segments -> third dropped; ovf=1 if WB_OVF_DETECT_EN is defined, else ovf=0; the first two segments drain intact.
REQ-038 SHALL cover reset mid-segment: rst=0 after 2 beats of row 0 -> outputs zero; after release a fresh 4-beat row 0 yields wr_addr 0 and no stale data.
